multicycle_control_fsm: RTL and testbench

- Multi-cycle sequencer for the 16-bit RISC datapath. It turns the 3-bit opcode into per-state control strobes: RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc and ALUOp.
- It adds PC/IR write enables, a data-memory ready handshake with timeout, halt/trap handling and a retired-instruction counter.
- It sits beside the datapath and replaces single-cycle opcode decoding.

---
 rtl/multicycle_control_fsm_pkg.sv | 29 ++
 rtl/multicycle_control_fsm_mem_wait_timer.sv | 26 ++
 rtl/multicycle_control_fsm.sv | 156 +++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle control sequencer: states, opcodes,
// ALU operation classes and trap causes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_t;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_LW    = 3'b010;
  localparam logic [2:0] OP_SW    = 3'b011;
  localparam logic [2:0] OP_BEQ   = 3'b100;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_MEMTO   = 2'b10;

  // 101 and 110 are the only unassigned encodings.
  function automatic logic op_legal(input logic [2:0] op);
    return !(op == 3'b101 || op == 3'b110);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Counts MEM cycles spent without MemReady and pulses timeout on the last
// allowed cycle so the sequencer can trap instead of waiting again.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic enable,
  input  logic clear,
  input  logic MemReady,
  output logic timeout
);

  localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

  logic [7:0] cnt;

  assign timeout = enable && !MemReady && (cnt == LAST);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)                cnt <= '0;
    else if (clear || timeout)  cnt <= '0;
    else if (enable)            cnt <= cnt + 8'd1;
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the 16-bit RISC datapath: per-state
// control strobes, memory-ready wait with timeout, halt/trap, retire counter.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic [2:0]       Opcode,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             Branch,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             MemToReg,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic             Busy,
  output logic             Halted,
  output logic             Trap,
  output logic [1:0]       TrapCause,
  output logic [CNT_W-1:0] Retired
);

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [1:0]       cause_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             mem_en, mem_to;

  assign mem_en = (state_q == S_MEM);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .enable   (mem_en),
    .clear    (!mem_en || MemReady),
    .MemReady (MemReady),
    .timeout  (mem_to)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= S_IDLE;
      op_q      <= OP_RTYPE;
      cause_q   <= TRAP_NONE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= Opcode;
      if (retire) retired_q <= retired_q + 1'b1;
      if (state_q == S_DECODE && !op_legal(Opcode)) cause_q <= TRAP_ILLEGAL;
      else if (mem_to)                              cause_q <= TRAP_MEMTO;
    end
  end

  // Strobes depend on state and op_q only; PCWrite in MEM also sees MemReady.
  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    Branch   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = ALUOP_ADD;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_FETCH;
      S_FETCH: begin
        IRWrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (Opcode == OP_HALT)      state_d = S_HALT;
        else if (!op_legal(Opcode)) state_d = S_TRAP;
        else                        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          OP_RTYPE: begin
            ALUOp   = ALUOP_FUNCT;
            state_d = S_WB;
          end
          OP_ADDI: begin
            ALUSrc  = 1'b1;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            ALUSrc  = 1'b1;
            state_d = S_MEM;
          end
          OP_BEQ: begin
            ALUOp   = ALUOP_SUB;
            Branch  = 1'b1;
            PCWrite = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        ALUSrc   = 1'b1;
        MemRead  = (op_q == OP_LW);
        MemWrite = (op_q == OP_SW);
        if (MemReady) begin
          if (op_q == OP_SW) begin
            PCWrite = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (mem_to) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
        case (op_q)
          OP_RTYPE: begin
            RegDst = 1'b1;
            ALUOp  = ALUOP_FUNCT;
          end
          OP_LW: begin
            ALUSrc   = 1'b1;
            MemToReg = 1'b1;
          end
          default: ALUSrc = 1'b1;
        endcase
      end
      default: state_d = state_q;
    endcase
  end

  assign Busy      = !(state_q == S_IDLE || state_q == S_HALT || state_q == S_TRAP);
  assign Halted    = (state_q == S_HALT);
  assign Trap      = (state_q == S_TRAP);
  assign TrapCause = cause_q;
  assign Retired   = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed-vector bench for multicycle_control_fsm with hand-computed strobe
// vectors {PCW,IRW,RegDst,Branch,MemRd,MemWr,RegWr,MemToReg,ALUSrc,ALUOp}.
module tb_multicycle_control_fsm;

  localparam int CNT_W = 4;

  logic             Clock = 1'b0;
  logic             Resetn = 1'b0;
  logic             Start = 1'b0;
  logic [2:0]       Opcode = 3'b000;
  logic             MemReady = 1'b0;
  logic             PCWrite, IRWrite, RegDst, Branch, MemRead, MemWrite;
  logic             RegWrite, MemToReg, ALUSrc;
  logic [1:0]       ALUOp;
  logic             Busy, Halted, Trap;
  logic [1:0]       TrapCause;
  logic [CNT_W-1:0] Retired;
  logic [10:0]      strb;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [10:0] ST_ZERO  = 11'b000_0000_0000;
  localparam logic [10:0] ST_FETCH = 11'b010_0000_0000;
  localparam logic [10:0] ST_EX_R  = 11'b000_0000_0010;
  localparam logic [10:0] ST_WB_R  = 11'b101_0001_0010;
  localparam logic [10:0] ST_EX_I  = 11'b000_0000_0100;
  localparam logic [10:0] ST_MEM_L = 11'b000_0100_0100;
  localparam logic [10:0] ST_MEM_S = 11'b000_0010_0100;
  localparam logic [10:0] ST_SW_OK = 11'b100_0010_0100;
  localparam logic [10:0] ST_WB_L  = 11'b100_0001_1100;
  localparam logic [10:0] ST_WB_A  = 11'b100_0001_0100;
  localparam logic [10:0] ST_EX_B  = 11'b100_1000_0001;

  multicycle_control_fsm #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Opcode(Opcode),
    .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .Branch(Branch), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .Busy(Busy), .Halted(Halted),
    .Trap(Trap), .TrapCause(TrapCause), .Retired(Retired)
  );

  assign strb = {PCWrite, IRWrite, RegDst, Branch, MemRead, MemWrite,
                 RegWrite, MemToReg, ALUSrc, ALUOp};

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Start = 1'b0;
    MemReady = 1'b0;
    Resetn = 1'b0;
    #2;
    Resetn = 1'b1;
  endtask

  always @(negedge Clock)
    if (Resetn && MemWrite) chk("mw_rw_excl", 32'(RegWrite), 32'd0);

  initial begin
    #7;
    chk("rst_strb", 32'(strb), 32'(ST_ZERO));
    chk("rst_flags", {29'd0, Busy, Halted, Trap}, 32'd0);
    chk("rst_cause", 32'(TrapCause), 32'd0);
    chk("rst_ret", 32'(Retired), 32'd0);
    Resetn = 1'b1;

    // R-type
    Start = 1'b1; Opcode = 3'b000;
    tick(); chk("r_fetch", 32'(strb), 32'(ST_FETCH)); chk("r_busy", 32'(Busy), 32'd1);
    tick(); chk("r_decode", 32'(strb), 32'(ST_ZERO));
    tick(); chk("r_exec", 32'(strb), 32'(ST_EX_R));
    tick(); chk("r_wb", 32'(strb), 32'(ST_WB_R));
    // LW with three cycles of MemReady low
    Opcode = 3'b010;
    tick(); chk("r_ret", 32'(Retired), 32'd1); chk("lw_fetch", 32'(strb), 32'(ST_FETCH));
    tick();
    tick(); chk("lw_exec", 32'(strb), 32'(ST_EX_I));
    for (int i = 0; i < 3; i++) begin
      tick(); chk("lw_mem_wait", 32'(strb), 32'(ST_MEM_L));
    end
    tick(); MemReady = 1'b1; #1; chk("lw_mem_ok", 32'(strb), 32'(ST_MEM_L));
    tick(); MemReady = 1'b0; #1; chk("lw_wb", 32'(strb), 32'(ST_WB_L));
    // ADDI, with MemReady high outside MEM to show it is ignored
    Opcode = 3'b001;
    tick(); chk("lw_ret", 32'(Retired), 32'd2); MemReady = 1'b1;
    tick();
    tick(); chk("addi_exec", 32'(strb), 32'(ST_EX_I));
    tick(); chk("addi_wb", 32'(strb), 32'(ST_WB_A));
    // BEQ
    Opcode = 3'b100;
    tick(); chk("addi_ret", 32'(Retired), 32'd3);
    tick();
    tick(); chk("beq_exec", 32'(strb), 32'(ST_EX_B));
    // SW, ready immediately
    Opcode = 3'b011;
    tick(); chk("beq_fetch", 32'(strb), 32'(ST_FETCH)); chk("beq_ret", 32'(Retired), 32'd4);
    tick();
    tick(); chk("sw_exec", 32'(strb), 32'(ST_EX_I));
    tick(); chk("sw_mem_ok", 32'(strb), 32'(ST_SW_OK));
    // SW, MemReady never arrives -> timeout trap after 15 MEM cycles
    tick(); chk("sw_ret", 32'(Retired), 32'd5); MemReady = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 15; i++) begin
      tick(); chk("swto_mem", 32'(strb), 32'(ST_MEM_S));
    end
    tick();
    chk("swto_trap", {29'd0, Busy, Halted, Trap}, 32'd1);
    chk("swto_cause", 32'(TrapCause), 32'd2);
    chk("swto_strb", 32'(strb), 32'(ST_ZERO));
    chk("swto_ret", 32'(Retired), 32'd5);

    // Retired wrap at 2^CNT_W using BEQs
    do_reset();
    Start = 1'b1; Opcode = 3'b100;
    tick();
    for (int i = 1; i <= 16; i++) begin
      tick(); tick(); tick();
      if (i == 15) chk("wrap_15", 32'(Retired), 32'd15);
    end
    chk("wrap_0", 32'(Retired), 32'd0);

    // Illegal opcode
    do_reset();
    Start = 1'b1; Opcode = 3'b101;
    tick(); tick(); tick();
    chk("ill_trap", {29'd0, Busy, Halted, Trap}, 32'd1);
    chk("ill_cause", 32'(TrapCause), 32'd1);

    // HALT, Start ignored afterwards
    do_reset();
    chk("halt_rst_cause", 32'(TrapCause), 32'd0);
    Start = 1'b1; Opcode = 3'b111;
    tick(); tick(); tick();
    chk("halt_flag", {29'd0, Busy, Halted, Trap}, 32'd2);
    tick(); tick();
    chk("halt_stay", {29'd0, Busy, Halted, Trap}, 32'd2);
    chk("halt_strb", 32'(strb), 32'(ST_ZERO));

    // Reset asserted mid-MEM drops MemRead asynchronously
    do_reset();
    Start = 1'b1; Opcode = 3'b010;
    tick(); tick(); tick(); tick();
    chk("mrst_mem", 32'(MemRead), 32'd1);
    Start = 1'b0;
    #2; Resetn = 1'b0; #1;
    chk("mrst_async", 32'(MemRead), 32'd0);
    #1; Resetn = 1'b1; #1;
    chk("mrst_idle", {29'd0, Busy, Halted, Trap}, 32'd0);
    chk("mrst_ret", 32'(Retired), 32'd0);
    tick(); chk("mrst_hold", 32'(strb), 32'(ST_ZERO));
    Start = 1'b1;
    tick(); chk("mrst_restart", 32'(strb), 32'(ST_FETCH));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
